// File: rtl/ahb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_pkg
// Brief    : Shared types and the byte-strobe helper for the AHB-Lite memory
//            slave (transfer/response/burst encodings, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package ahb_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Widest supported bus is 64 bits, so strobes never exceed 8 lanes.
    localparam int c_MAX_LANES = 8;

    // Little-endian byte strobes: lanes [offset, offset + 2^size) are set,
    // where offset is the byte position of the address within the bus word.
    function automatic logic [c_MAX_LANES-1:0] byte_strobe(
        input logic [2:0] size,
        input logic [2:0] addr_lo,
        input int         data_width
    );
        int                     lanes;
        int                     nbytes;
        int                     offset;
        logic [c_MAX_LANES-1:0] strb;
        lanes  = data_width / 8;
        nbytes = 1 << size;
        offset = int'(addr_lo) % lanes;
        strb   = '0;
        for (int k = 0; k < c_MAX_LANES; k++) begin
            if ((k < lanes) && (k >= offset) && (k < offset + nbytes)) begin
                strb[k] = 1'b1;
            end
        end
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_array
// Brief    : MEM_DEPTH x DATA_WIDTH storage with a byte-enabled synchronous
//            write port and an asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_array
    import ahb_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
)(
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH/8-1:0]      i_wstrb,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Byte-lane write; lanes with a clear strobe keep their old contents
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (i_wstrb[k]) begin
                    r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Brief    : Parametrised AHB-Lite leaf memory slave with programmable wait
//            states, HSIZE byte-lane writes and a two-cycle ERROR response.
//            Optional macro AHB_MEM_BURST_CHECK_EN adds SEQ address checking.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_mem_slave
    import ahb_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
)(
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            HRESP,
    input  logic                  HREADYin,
    output logic                  HREADYout
);

    localparam int                    c_BYTES     = DATA_WIDTH / 8;
    localparam int                    c_LANE_BITS = $clog2(c_BYTES);
    localparam int                    c_IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_SPAN      = (ADDR_WIDTH+1)'(MEM_DEPTH * c_BYTES);
    localparam logic [ADDR_WIDTH:0]   c_LIMIT     = {1'b0, BASE_ADDR} + c_SPAN;
    localparam logic [3:0]            c_WAIT      = 4'(WAIT_STATES);

    state_e                r_state;
    state_e                w_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic                  r_dphase;

    logic                  w_ready;
    logic                  w_sample;
    logic                  w_legal;
    logic                  w_seq_ok;
    logic [6:0]            w_align_mask;
    logic                  w_in_range;
    logic                  w_aligned;
    logic                  w_size_ok;

    logic [ADDR_WIDTH-1:0] w_off;
    logic [c_IDX_W-1:0]    w_idx;
    logic [7:0]            w_strb8;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    // Only IDLE and ERR2 present HREADYout high; nothing is sampled otherwise.
    assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_sample  = HSEL && HREADYin && HTRANS[1] && w_ready;
    assign HREADYout = w_ready;
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Legality decode of the address phase currently on the bus
    always_comb begin
        w_align_mask = 7'((8'd1 << HSIZE) - 8'd1);
        w_in_range   = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < c_LIMIT);
        w_aligned    = (HADDR[6:0] & w_align_mask) == 7'd0;
        w_size_ok    = (HSIZE <= 3'(c_LANE_BITS));
        w_legal      = w_in_range && w_aligned && w_size_ok && w_seq_ok;
    end

`ifdef AHB_MEM_BURST_CHECK_EN
    logic [ADDR_WIDTH-1:0] r_prev_addr;
    logic                  r_prev_valid;
    logic [ADDR_WIDTH-1:0] w_seq_expect;
    logic                  w_wrap;

    // SEQ beats must follow the previous beat and stay inside a 1 KB page
    always_comb begin
        w_wrap       = (HBURST == HBURST_WRAP4) || (HBURST == HBURST_WRAP8) ||
                       (HBURST == HBURST_WRAP16);
        w_seq_expect = r_prev_addr + ADDR_WIDTH'(8'd1 << HSIZE);
        w_seq_ok     = 1'b1;
        if (HTRANS == HTRANS_SEQ) begin
            w_seq_ok = r_prev_valid &&
                       (HADDR[ADDR_WIDTH-1:10] == r_prev_addr[ADDR_WIDTH-1:10]) &&
                       (w_wrap || (HADDR == w_seq_expect));
        end
    end

    // Burst context: every sampled NONSEQ restarts it, each SEQ advances it
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_prev_addr  <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_sample) begin
            r_prev_addr  <= HADDR;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_unused = ^{w_off, w_strb8};
`else
    assign w_seq_ok = 1'b1;
    assign w_unused = ^{HBURST, HTRANS[0], w_off, w_strb8};
`endif

    // Address-phase capture; r_dphase marks a pending OKAY data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_dphase <= 1'b0;
        end else if (w_ready) begin
            r_dphase <= w_sample && w_legal;
            if (w_sample) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    // FSM state and wait counter register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state decode; ERR2 accepts a new address phase exactly like IDLE
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_next = ST_IDLE;
                if (w_sample) begin
                    if (!w_legal) begin
                        w_next = ST_ERR1;
                    end else if (c_WAIT != 4'd0) begin
                        w_next     = ST_WAIT;
                        w_cnt_next = c_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    // Write commits at the edge that closes an OKAY write data phase, so a
    // read issued back-to-back sees the new data through the async port.
    assign w_off   = r_addr - BASE_ADDR;
    assign w_idx   = w_off[c_LANE_BITS +: c_IDX_W];
    assign w_strb8 = byte_strobe(r_size, w_off[2:0], DATA_WIDTH);
    assign w_we    = w_ready && r_dphase && r_write;
    assign HRDATA  = (w_ready && r_dphase && !r_write) ? w_rdata : '0;

    ahb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk     (HCLK),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wstrb (w_strb8[c_BYTES-1:0]),
        .i_wdata (HWDATA),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_mem_slave
// Brief    : Self-checking bench for ahb_lite_mem_slave (zero-wait and
//            two-wait-state instances sharing one bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

    localparam logic [1:0] c_ID = 2'b00;
    localparam logic [1:0] c_NS = 2'b10;
    localparam logic [1:0] c_SQ = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic [1:0]  hresp0, hresp1;
    logic        hready0, hready1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mdl [0:1023];

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic [1:0]  rsp;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_slave #(.WAIT_STATES(0)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HRDATA(hrdata0), .HRESP(hresp0),
        .HREADYin(hready0), .HREADYout(hready0)
    );

    ahb_lite_mem_slave #(.WAIT_STATES(2)) u_dut_ws (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HRDATA(hrdata1), .HRESP(hresp1),
        .HREADYin(hready1), .HREADYout(hready1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic s0, input logic s1, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        hsel0  = s0;
        hsel1  = s1;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        hburst = 3'd1;
    endtask

    function automatic logic [31:0] mdl_word(input int a);
        int w;
        w = a & ~3;
        return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
    endfunction

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
        v.rdy = rdy; v.rsp = rsp; v.rd = rd;
        return v;
    endfunction

    // One isolated transfer on the zero-wait slave, checked against the byte model
    task automatic model_xfer(input string nm, input int a, input int sz, input logic wr,
                              input logic [31:0] d);
        int nb;
        bit legal;
        nb    = 1 << sz;
        legal = (a < 1024) && ((a % nb) == 0) && (nb <= 4);
        drive(1'b1, 1'b0, c_NS, wr, 3'(sz), 32'(a), 32'h0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, d);
        @(negedge HCLK);
        if (legal) begin
            check({nm, " rdy"},   32'(hready0), 32'd1);
            check({nm, " resp"},  32'(hresp0),  32'd0);
            check({nm, " rdata"}, hrdata0, wr ? 32'd0 : mdl_word(a));
            if (wr) begin
                for (int b = a; b < a + nb; b++) mdl[b] = d[8*(b%4) +: 8];
            end
            tick;
        end else begin
            check({nm, " err1 rdy"},   32'(hready0), 32'd0);
            check({nm, " err1 resp"},  32'(hresp0),  32'd1);
            check({nm, " err1 rdata"}, hrdata0,      32'd0);
            tick;
            @(negedge HCLK);
            check({nm, " err2 rdy"},  32'(hready0), 32'd1);
            check({nm, " err2 resp"}, 32'(hresp0),  32'd1);
            tick;
        end
    endtask

    // Counts HREADYout-low cycles of the wait-state slave, then checks completion
    task automatic ws_measure(input string nm, input logic [31:0] exp);
        int lows;
        bit done;
        lows = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge HCLK);
            if (hready1) begin
                done = 1;
            end else begin
                lows++;
                check({nm, " wait rdata"}, hrdata1, 32'd0);
                @(posedge HCLK);
                #1;
            end
        end
        check({nm, " low cycles"}, 32'(lows), 32'd2);
        check({nm, " rdata"}, hrdata1, exp);
        check({nm, " resp"}, 32'(hresp1), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp28;
        drive(1'b0, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h0);
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("reset rdy",     32'(hready0), 32'd1);
        check("reset resp",    32'(hresp0),  32'd0);
        check("reset rdata",   hrdata0,      32'd0);
        check("reset ws rdy",  32'(hready1), 32'd1);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Fill all of memory so every later read has a known model value
        for (int w = 0; w < 256; w++) model_xfer("fill", w * 4, 2, 1'b1, $urandom);

        // Random isolated transfers including out-of-range, misaligned, oversize
        for (int n = 0; n < 300; n++) begin
            int a, sz;
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, 1151);
            if ($urandom_range(0, 4) != 0) a = a & ~((1 << sz) - 1);
            model_xfer("rand", a, sz, 1'($urandom_range(0, 1)), $urandom);
        end

        // Pipelined vectors: {sel, trans, write, size, addr, wdata | ready, resp, rdata}
        tbl.push_back(mk(1, c_NS, 1, 2, 32'h000, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 1, 0, 32'h002, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h000, 32'h00050000, 1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'h00050000));
        tbl.push_back(mk(1, c_NS, 1, 2, 32'h010, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_SQ, 1, 2, 32'h014, 32'h11,       1, 0, 32'h0));
        tbl.push_back(mk(1, c_SQ, 1, 2, 32'h018, 32'h22,       1, 0, 32'h0));
        tbl.push_back(mk(1, c_SQ, 1, 2, 32'h01C, 32'h33,       1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h010, 32'h44,       1, 0, 32'h0));
        tbl.push_back(mk(1, c_SQ, 0, 2, 32'h014, 32'h0,        1, 0, 32'h11));
        tbl.push_back(mk(1, c_SQ, 0, 2, 32'h018, 32'h0,        1, 0, 32'h22));
        tbl.push_back(mk(1, c_SQ, 0, 2, 32'h01C, 32'h0,        1, 0, 32'h33));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'h44));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h400, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 1, 2, 32'h002, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'hDEADBEEF, 0, 1, 32'h0));
        tbl.push_back(mk(0, c_NS, 0, 2, 32'h000, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h000, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'h00050000));
        tbl.push_back(mk(1, c_NS, 1, 3, 32'h010, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h010, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'h11));
        tbl.push_back(mk(1, c_NS, 1, 1, 32'h012, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h010, 32'hBEEF0000, 1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'hBEEF0011));
        tbl.push_back(mk(1, c_NS, 1, 2, 32'h3FC, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, c_NS, 0, 2, 32'h3FC, 32'hCAFEF00D, 1, 0, 32'h0));
        tbl.push_back(mk(1, c_ID, 0, 0, 32'h000, 32'h0,        1, 0, 32'hCAFEF00D));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, 1'b0, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd);
            @(negedge HCLK);
            check($sformatf("vec%0d rdy", i),   32'(hready0), 32'(tbl[i].rdy));
            check($sformatf("vec%0d resp", i),  32'(hresp0),  32'(tbl[i].rsp));
            check($sformatf("vec%0d rdata", i), hrdata0,      tbl[i].rd);
            tick;
        end

        // Reset in the middle of a write data phase: the write must be dropped
        drive(1'b1, 1'b0, c_NS, 1'b1, 3'd2, 32'h4, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h12345678);
        tick;
        drive(1'b1, 1'b0, c_NS, 1'b1, 3'd2, 32'h4, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h000000AA);
        #1;
        HRESETn = 1'b0;
        #1;
        check("midrst rdy",   32'(hready0), 32'd1);
        check("midrst resp",  32'(hresp0),  32'd0);
        check("midrst rdata", hrdata0,      32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        drive(1'b1, 1'b0, c_NS, 1'b0, 3'd2, 32'h4, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge HCLK);
        check("midrst keep", hrdata0, 32'h12345678);
        tick;

        // Two wait states; the held next address must be taken only once
        drive(1'b0, 1'b1, c_NS, 1'b1, 3'd2, 32'h10, 32'h0);
        tick;
        drive(1'b0, 1'b1, c_ID, 1'b0, 3'd0, 32'h0, 32'h11);
        ws_measure("ws wr", 32'h0);
        tick;
        drive(1'b0, 1'b1, c_NS, 1'b0, 3'd2, 32'h10, 32'h0);
        tick;
        ws_measure("ws rd1", 32'h11);
        tick;
        drive(1'b0, 1'b1, c_ID, 1'b0, 3'd0, 32'h0, 32'h0);
        ws_measure("ws rd2", 32'h11);
        tick;
        @(negedge HCLK);
        check("ws after rdy",   32'(hready1), 32'd1);
        check("ws after rdata", hrdata1,      32'd0);
        tick;

        // NONSEQ 0x20 followed by a non-incrementing SEQ 0x28
        drive(1'b1, 1'b0, c_NS, 1'b1, 3'd2, 32'h28, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h77);
        tick;
        drive(1'b1, 1'b0, c_NS, 1'b1, 3'd2, 32'h20, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_SQ, 1'b1, 3'd2, 32'h28, 32'h55);
        @(negedge HCLK);
        check("burst beat0 rdy",  32'(hready0), 32'd1);
        check("burst beat0 resp", 32'(hresp0),  32'd0);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h66);
        @(negedge HCLK);
`ifdef AHB_MEM_BURST_CHECK_EN
        exp28 = 32'h77;
        check("burst seq err1 rdy",  32'(hready0), 32'd0);
        check("burst seq err1 resp", 32'(hresp0),  32'd1);
        tick;
        @(negedge HCLK);
        check("burst seq err2 rdy",  32'(hready0), 32'd1);
        check("burst seq err2 resp", 32'(hresp0),  32'd1);
        tick;
`else
        exp28 = 32'h66;
        check("burst seq rdy",  32'(hready0), 32'd1);
        check("burst seq resp", 32'(hresp0),  32'd0);
        tick;
`endif
        drive(1'b1, 1'b0, c_NS, 1'b0, 3'd2, 32'h28, 32'h0);
        tick;
        drive(1'b1, 1'b0, c_NS, 1'b0, 3'd2, 32'h20, 32'h0);
        @(negedge HCLK);
        check("burst rd 0x28", hrdata0, exp28);
        tick;
        drive(1'b1, 1'b0, c_ID, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge HCLK);
        check("burst rd 0x20", hrdata0, 32'h55);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
